// File: rtl/systolic_operand_loader.sv
// Operand loader for the NxN systolic multiplier: streams A then B into register
// banks, runs the multiplier under load_en, and waits for cal_finish or a timeout.
module systolic_operand_loader #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned N      = 12,
    parameter int unsigned CW     = $clog2(N + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DWIDTH-1:0]                  in_data,
    input  logic [CW-1:0]                      n_cols,
    output logic [N-1:0][N-1:0][DWIDTH-1:0]    a_row,
    output logic [N-1:0][N-1:0][DWIDTH-1:0]    b_col,
    output logic                               load_en,
    output logic                               enb_1,
    output logic                               enb_2_6,
    output logic                               enb_7_12,
    input  logic                               cal_finish,
    output logic                               done,
    output logic                               err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW = $clog2(4 * N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [RW-1:0] RUN_MIN  = RW'(2 * N - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(4 * N - 1);
    localparam logic [CW-1:0] N_COLS_MAX = CW'(N);

    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        RUN    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   row_q, row_d;
    logic [IW-1:0]   col_q, col_d;
    logic [RW-1:0]   run_cnt_q, run_cnt_d;
    logic            load_en_q, load_en_d;
    logic            enb_1_q, enb_1_d;
    logic            enb_2_6_q, enb_2_6_d;
    logic            enb_7_12_q, enb_7_12_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [N-1:0][N-1:0][DWIDTH-1:0] a_q, b_q;

    logic            beat;
    logic            last_elem;
    logic            normal_exit;
    logic [CW-1:0]   n_eff;

    assign in_ready    = (state_q == FILL_A) || (state_q == FILL_B);
    assign beat        = in_valid && in_ready;
    assign last_elem   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign normal_exit = (run_cnt_q >= RUN_MIN) && cal_finish;
    assign n_eff       = (n_cols > N_COLS_MAX) ? N_COLS_MAX : n_cols;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        run_cnt_d  = run_cnt_q;
        load_en_d  = load_en_q;
        enb_1_d    = enb_1_q;
        enb_2_6_d  = enb_2_6_q;
        enb_7_12_d = enb_7_12_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (flush) begin
            state_d    = FILL_A;
            row_d      = '0;
            col_d      = '0;
            run_cnt_d  = '0;
            load_en_d  = 1'b0;
            enb_1_d    = 1'b0;
            enb_2_6_d  = 1'b0;
            enb_7_12_d = 1'b0;
        end else begin
            case (state_q)
                FILL_A, FILL_B: begin
                    if (beat) begin
                        if (col_q == LAST_IDX) begin
                            col_d = '0;
                            row_d = row_q + IW'(1);
                        end else begin
                            col_d = col_q + IW'(1);
                        end
                        if (last_elem) begin
                            row_d = '0;
                            col_d = '0;
                            if (state_q == FILL_A) begin
                                state_d = FILL_B;
                            end else begin
                                state_d    = RUN;
                                load_en_d  = 1'b1;
                                run_cnt_d  = '0;
                                enb_1_d    = (n_eff >= CW'(1));
                                enb_2_6_d  = (n_eff >= CW'(2));
                                enb_7_12_d = (n_eff >= CW'(7));
                            end
                        end
                    end
                end
                RUN: begin
                    run_cnt_d = run_cnt_q + RW'(1);
                    // The run_cnt floor masks a cal_finish left high from the previous run
                    if (normal_exit || (run_cnt_q == RUN_MAX)) begin
                        state_d    = FILL_A;
                        run_cnt_d  = '0;
                        load_en_d  = 1'b0;
                        enb_1_d    = 1'b0;
                        enb_2_6_d  = 1'b0;
                        enb_7_12_d = 1'b0;
                        done_d     = 1'b1;
                        err_d      = !normal_exit;
                    end
                end
                default: begin
                    state_d = FILL_A;
                end
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL_A;
            row_q      <= '0;
            col_q      <= '0;
            run_cnt_q  <= '0;
            load_en_q  <= 1'b0;
            enb_1_q    <= 1'b0;
            enb_2_6_q  <= 1'b0;
            enb_7_12_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            run_cnt_q  <= run_cnt_d;
            load_en_q  <= load_en_d;
            enb_1_q    <= enb_1_d;
            enb_2_6_q  <= enb_2_6_d;
            enb_7_12_q <= enb_7_12_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Operand banks; a flush drops a coincident beat but keeps prior contents
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (beat && !flush) begin
            if (state_q == FILL_A) begin
                a_q[row_q][col_q] <= in_data;
            end else begin
                b_q[row_q][col_q] <= in_data;
            end
        end
    end

    assign a_row    = a_q;
    assign b_col    = b_q;
    assign load_en  = load_en_q;
    assign enb_1    = enb_1_q;
    assign enb_2_6  = enb_2_6_q;
    assign enb_7_12 = enb_7_12_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
